pe_dot_mac: RTL and testbench
=============================

# pe_dot_mac

Parametrised, pipelined signed fixed-point dot-product MAC for the PE array. Each beat multiplies TAPS weight/activation pairs, sums them at full precision, and accumulates across a multi-beat group seeded by an incoming partial sum. At group end the result is rescaled by FRAC with optional rounding and saturated to DW bits. It sits between the PE scratchpads and the psum output path, with valid/ready on both sides.

## Interface
- DW, 16: operand and result width, signed two's complement.
- FRAC, 12: fractional bits of operands and result (Q(DW-FRAC).FRAC); 0 ≤ FRAC < DW.
- TAPS, 3: products per beat; ≥ 1.
- ACCW, 40: accumulator width; ≥ 2*DW + $clog2(TAPS) + 1.

- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_a  in  TAPS*DW  activations, lane i at [i*DW +: DW].
- in_b  in  TAPS*DW  weights, same packing.
- in_first  in  1  beat opens a group; accumulator is seeded from psum_in.
- in_last  in  1  beat closes a group and produces one output.
- psum_in  in  DW  Q-format partial sum, sampled only on a first beat.
- mode_round  in  1  sampled with the last beat: 1 = round-half-up, 0 = truncate (floor).
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  DW  saturated result.
- out_sat  out  1  result was clipped; qualified by out_valid.

## Operation
- Stage S1 registers TAPS full-precision 2*DW signed products, plus first/last/psum_in/mode_round.
- Stage S2 sign-extends the products to ACCW, sums them, and registers the beat sum.
- Stage S3 handles accumulation:
  - On a first beat: acc = sext(psum_in) << FRAC + beat sum.
  - Otherwise: acc = acc + beat sum.
  - The accumulator wraps modulo 2^ACCW; there is no intermediate saturation.
- Finalisation on a last beat:
  - v = acc_new + (mode_round && FRAC > 0 ? 2^(FRAC-1) : 0).
  - r = v >>> FRAC (arithmetic shift).
  - If r > 2^(DW-1)-1 then out_data = 0x7FFF… and out_sat = 1.
  - If r < -2^(DW-1) then out_data = 0x8000… and out_sat = 1.
  - Otherwise out_data = r[DW-1:0] and out_sat = 0.
- Beats without in_last update the accumulator only and produce no output.
- first && last on the same beat is a single-beat group.
- A last beat with no preceding first accumulates onto the current accumulator, which is 0 after reset.
- A first beat arriving mid-group discards the old accumulator.
- After a last beat the accumulator holds acc_new until the next first beat.

## Timing
- Reset values:
  - in_ready = 1.
  - out_valid = 0, out_data = 0, out_sat = 0.
  - Accumulator = 0 and all stage valid bits = 0.
- Reset acts immediately; no output completes across a reset.
- Latency: a last beat accepted at edge t gives out_valid high after edge t+3.
- Throughput: one beat per cycle.
- Stall rule: global enable en = !out_valid || out_ready, and in_ready = en.
  - in_ready depends combinationally on out_ready.
  - Every stage, including the accumulator, advances only when en = 1.
  - out_data and out_sat hold stable while out_valid && !out_ready.
- Bubbles (in_valid = 0 with en = 1) advance the pipeline with invalid stage bits and leave the accumulator unchanged.
- Outputs appear in acceptance order; beats are never dropped or duplicated.

## Test plan
Values below use DW=16, FRAC=12, so 1.0 = 0x1000.
- Single beat, first = last = 1, a = {0x1000,0x1000,0x1000}, b = {0x0800,0x0400,0x0400}, psum_in = 0, truncate -> out_data = 0x1000, out_sat = 0, out_valid 3 cycles after acceptance.
- Saturation:
  - a = b = all 0x7FFF -> out_data = 0x7FFF, out_sat = 1.
  - a = all 0x8000, b = all 0x7FFF -> out_data = 0x8000, out_sat = 1.
- Rounding: a0 = 0x0001, b0 = 0x0800, other lanes 0:
  - truncate -> 0x0000; round -> 0x0001.
  - With a0 = 0xFFFF: truncate -> 0xFFFF; round -> 0x0000.
- Three-beat group (first, mid, last), each beat a0 = b0 = 0x1000 with other lanes 0, psum_in = 0x0800 -> exactly one output, 0x3800; no out_valid for the first two beats.
- Backpressure: four back-to-back single-beat groups with out_ready held low for 5 cycles -> in_ready drops; all four results appear in order, unchanged while stalled, none lost.
- Assert rst mid-group with an output pending -> out_valid falls asynchronously. A following first&last group of 0x1000 × 0x1000 (lane 0 only, psum_in = 0) -> out_data = 0x1000 with no residue from before reset.

Source files
------------

// File: rtl/pe_dot_mac.sv
// Pipelined signed fixed-point dot-product MAC: TAPS products per beat, accumulated
// across a first..last group seeded by psum_in, then rescaled, rounded and saturated.
module pe_dot_mac #(
    parameter int DW   = 16,
    parameter int FRAC = 12,
    parameter int TAPS = 3,
    parameter int ACCW = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TAPS*DW-1:0] in_a,
    input  logic [TAPS*DW-1:0] in_b,
    input  logic               in_first,
    input  logic               in_last,
    input  logic [DW-1:0]      psum_in,
    input  logic               mode_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic               out_sat
);

    localparam logic signed [ACCW-1:0] HALF = (ACCW'(1) << FRAC) >> 1;
    localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MINV = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // S1: products
    logic                   v1, first1, last1, rnd1;
    logic [DW-1:0]          psum1;
    logic signed [2*DW-1:0] prod1 [TAPS];
    logic signed [2*DW-1:0] prod_c [TAPS];

    always_comb begin
        for (int unsigned i = 0; i < TAPS; i++) begin
            prod_c[i] = (2*DW)'($signed(in_a[i*DW +: DW])) * (2*DW)'($signed(in_b[i*DW +: DW]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            first1 <= 1'b0;
            last1  <= 1'b0;
            rnd1   <= 1'b0;
            psum1  <= '0;
            for (int unsigned i = 0; i < TAPS; i++) prod1[i] <= '0;
        end else if (en) begin
            v1     <= in_valid;
            first1 <= in_first;
            last1  <= in_last;
            rnd1   <= mode_round;
            psum1  <= psum_in;
            for (int unsigned i = 0; i < TAPS; i++) prod1[i] <= prod_c[i];
        end
    end

    // S2: beat sum at accumulator width
    logic                   v2, first2, last2, rnd2;
    logic [DW-1:0]          psum2;
    logic signed [ACCW-1:0] sum2;
    logic signed [ACCW-1:0] sum_c;

    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < TAPS; i++) begin
            sum_c = sum_c + ACCW'(prod1[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2     <= 1'b0;
            first2 <= 1'b0;
            last2  <= 1'b0;
            rnd2   <= 1'b0;
            psum2  <= '0;
            sum2   <= '0;
        end else if (en) begin
            v2     <= v1;
            first2 <= first1;
            last2  <= last1;
            rnd2   <= rnd1;
            psum2  <= psum1;
            sum2   <= sum_c;
        end
    end

    // S3: accumulator; fin3 marks that acc now holds a completed group
    logic                   fin3, rnd3;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_base, acc_new;

    always_comb begin
        acc_base = first2 ? (ACCW'($signed(psum2)) << FRAC) : acc;
        acc_new  = acc_base + sum2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            fin3 <= 1'b0;
            rnd3 <= 1'b0;
        end else if (en) begin
            if (v2) acc <= acc_new;
            fin3 <= v2 && last2;
            rnd3 <= rnd2;
        end
    end

    // Output stage: rescale from the settled accumulator, round, saturate
    logic signed [ACCW-1:0] v_fin, r_fin;

    always_comb begin
        v_fin = acc + (rnd3 ? HALF : '0);
        r_fin = v_fin >>> FRAC;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= fin3;
            if (fin3) begin
                if (r_fin > MAXV) begin
                    out_data <= {1'b0, {(DW-1){1'b1}}};
                    out_sat  <= 1'b1;
                end else if (r_fin < MINV) begin
                    out_data <= {1'b1, {(DW-1){1'b0}}};
                    out_sat  <= 1'b1;
                end else begin
                    out_data <= r_fin[DW-1:0];
                    out_sat  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_dot_mac.sv
// Directed bench for pe_dot_mac at DW=16, FRAC=12, TAPS=3.
module tb_pe_dot_mac;

    localparam int DW   = 16;
    localparam int TAPS = 3;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [TAPS*DW-1:0] in_a;
    logic [TAPS*DW-1:0] in_b;
    logic               in_first;
    logic               in_last;
    logic [DW-1:0]      psum_in;
    logic               mode_round;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_data;
    logic               out_sat;

    int n_tests = 0;
    int n_fail  = 0;

    pe_dot_mac #(.DW(16), .FRAC(12), .TAPS(3), .ACCW(40)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .in_first(in_first), .in_last(in_last),
        .psum_in(psum_in), .mode_round(mode_round),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [15:0] a0, a1, a2, b0, b1, b2,
                        input logic first, last, input logic [15:0] psum, input logic rnd);
        bit done = 0;
        in_a       = {a2, a1, a0};
        in_b       = {b2, b1, b0};
        in_first   = first;
        in_last    = last;
        psum_in    = psum;
        mode_round = rnd;
        in_valid   = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            if (in_ready) done = 1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_out(input string tag, input logic [15:0] exp_d, input logic exp_s);
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (out_valid) seen = 1;
            else tick();
        end
        check({tag, "_valid"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_data"}, 32'(out_data), 32'(exp_d));
            check({tag, "_sat"},  32'(out_sat),  32'(exp_s));
            tick();
        end
    endtask

    initial begin
        logic [15:0] got [4];
        int          cnt;
        logic [15:0] d3;
        bit          pend;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_first = 1'b0;
        in_last = 1'b0; psum_in = '0; mode_round = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_sat",   32'(out_sat),   32'd0);
        @(negedge clk); rst = 1'b0;
        tick();

        // single beat with latency
        send(16'h1000, 16'h1000, 16'h1000, 16'h0800, 16'h0400, 16'h0400, 1, 1, 16'h0000, 0);
        check("lat_t0", 32'(out_valid), 32'd0);
        tick(); check("lat_t1", 32'(out_valid), 32'd0);
        tick(); check("lat_t2", 32'(out_valid), 32'd0);
        tick(); check("lat_t3", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'h1000);
        check("single_sat",  32'(out_sat),  32'd0);
        tick();

        // saturation
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1, 1, 16'h0000, 0);
        wait_out("sat_pos", 16'h7FFF, 1'b1);
        send(16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1, 1, 16'h0000, 0);
        wait_out("sat_neg", 16'h8000, 1'b1);

        // rounding
        send(16'h0001, 0, 0, 16'h0800, 0, 0, 1, 1, 16'h0000, 0);
        wait_out("rnd_pos_trunc", 16'h0000, 1'b0);
        send(16'h0001, 0, 0, 16'h0800, 0, 0, 1, 1, 16'h0000, 1);
        wait_out("rnd_pos_round", 16'h0001, 1'b0);
        send(16'hFFFF, 0, 0, 16'h0800, 0, 0, 1, 1, 16'h0000, 0);
        wait_out("rnd_neg_trunc", 16'hFFFF, 1'b0);
        send(16'hFFFF, 0, 0, 16'h0800, 0, 0, 1, 1, 16'h0000, 1);
        wait_out("rnd_neg_round", 16'h0000, 1'b0);

        // three-beat group
        cnt = 0; d3 = '0;
        send(16'h1000, 0, 0, 16'h1000, 0, 0, 1, 0, 16'h0800, 0);
        if (out_valid) cnt++;
        send(16'h1000, 0, 0, 16'h1000, 0, 0, 0, 0, 16'h0000, 0);
        if (out_valid) cnt++;
        send(16'h1000, 0, 0, 16'h1000, 0, 0, 0, 1, 16'h0000, 0);
        for (int k = 0; k < 8; k++) begin
            if (out_valid) begin cnt++; d3 = out_data; end
            tick();
        end
        check("grp3_count", 32'(cnt), 32'd1);
        check("grp3_data",  32'(d3),  32'h3800);

        // backpressure
        out_ready = 1'b0;
        send(16'h1000, 0, 0, 16'h1000, 0, 0, 1, 1, 16'h0000, 0);
        send(16'h1000, 0, 0, 16'h2000, 0, 0, 1, 1, 16'h0000, 0);
        send(16'h1000, 0, 0, 16'h3000, 0, 0, 1, 1, 16'h0000, 0);
        send(16'h1000, 0, 0, 16'h4000, 0, 0, 1, 1, 16'h0000, 0);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data",  32'(out_data),  32'h1000);
            tick();
        end
        out_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid && cnt < 4) begin got[cnt] = out_data; cnt++; end
            tick();
        end
        check("bp_count", 32'(cnt), 32'd4);
        check("bp_res0", 32'(got[0]), 32'h1000);
        check("bp_res1", 32'(got[1]), 32'h2000);
        check("bp_res2", 32'(got[2]), 32'h3000);
        check("bp_res3", 32'(got[3]), 32'h4000);

        // reset mid-group with an output pending
        out_ready = 1'b0;
        send(16'h2000, 0, 0, 16'h1000, 0, 0, 1, 1, 16'h0000, 0);
        send(16'h1000, 0, 0, 16'h1000, 0, 0, 1, 0, 16'h0400, 0);
        pend = 0;
        for (int k = 0; k < 10 && !pend; k++) begin
            if (out_valid) pend = 1;
            else tick();
        end
        check("rst_pending", 32'(pend), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_ready", 32'(in_ready),  32'd1);
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        tick();
        send(16'h1000, 0, 0, 16'h1000, 0, 0, 1, 1, 16'h0000, 0);
        wait_out("post_rst", 16'h1000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
